// File: rtl/elev_call_panel_if.sv
// Signal bundle between the floor call panel and the elevator controller.
// master = call panel side, slave = controller side.
interface elev_call_panel_if #(
    parameter int unsigned NUM_FLOORS = 4,
    parameter int unsigned FW         = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
);
    logic [NUM_FLOORS-1:0] btn_raw;
    logic [FW-1:0]         floor_sel;
    logic                  door;
    logic [NUM_FLOORS-1:0] floor_btn;
    logic [NUM_FLOORS-1:0] pending;
    logic                  busy;

    modport master (
        input  btn_raw, floor_sel, door,
        output floor_btn, pending, busy
    );

    modport slave (
        output btn_raw, floor_sel, door,
        input  floor_btn, pending, busy
    );
endinterface

// File: rtl/elev_call_panel.sv
// Floor call panel: synchronizes and debounces call buttons, latches pending calls and
// presents them one at a time in SCAN order, holding off for a door dwell after each service.
module elev_call_panel #(
    parameter int unsigned NUM_FLOORS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DWELL_CYCLES    = 8
) (
    input logic               clk,
    input logic               rst,
    elev_call_panel_if.master bus
);
    localparam int unsigned FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

    typedef enum logic [1:0] {StIdle, StPresent, StDwell} state_e;

    state_e                         state_q, state_d;
    logic [NUM_FLOORS-1:0]          sync1_q, sync2_q;
    logic [NUM_FLOORS-1:0][CW-1:0]  deb_q, deb_d;
    logic [NUM_FLOORS-1:0]          pending_q, pending_d;
    logic [NUM_FLOORS-1:0]          floor_btn_q, floor_btn_d;
    logic [FW-1:0]                  target_q, target_d;
    logic                           dir_up_q, dir_up_d;
    logic [DW-1:0]                  dwell_q, dwell_d;

    logic [NUM_FLOORS-1:0] accept;
    logic [NUM_FLOORS-1:0] svc;
    logic [FW-1:0]         cur, above_idx, below_idx, pick;
    logic                  above_found, below_found, pick_up;

    assign cur = bus.floor_sel;

    // Counter saturates at DEBOUNCE_CYCLES so a held button yields a single accept.
    always_comb begin
        accept = '0;
        deb_d  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (sync2_q[i]) begin
                deb_d[i] = deb_q[i];
                if (deb_q[i] != CW'(DEBOUNCE_CYCLES)) begin
                    deb_d[i] = deb_q[i] + 1'b1;
                end
                accept[i] = (deb_q[i] == CW'(DEBOUNCE_CYCLES - 1));
            end
        end
    end

    // An open door at a floor satisfies that floor; clearing beats a same-edge accept.
    always_comb begin
        svc       = bus.door ? (ONE << cur) : '0;
        pending_d = (pending_q | accept) & ~svc;
    end

    always_comb begin
        above_found = 1'b0;
        below_found = 1'b0;
        above_idx   = '0;
        below_idx   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FW'(i) > cur)) begin
                above_found = 1'b1;
                above_idx   = FW'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (FW'(i) < cur)) begin
                below_found = 1'b1;
                below_idx   = FW'(i);
            end
        end
        pick    = cur;
        pick_up = dir_up_q;
        if (pending_q[cur]) begin
            pick = cur;
        end else if (dir_up_q) begin
            if (above_found) begin
                pick = above_idx;
            end else begin
                pick    = below_idx;
                pick_up = 1'b0;
            end
        end else begin
            if (below_found) begin
                pick = below_idx;
            end else begin
                pick    = above_idx;
                pick_up = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        floor_btn_d = floor_btn_q;
        target_d    = target_q;
        dir_up_d    = dir_up_q;
        dwell_d     = dwell_q;
        case (state_q)
            StIdle: begin
                floor_btn_d = '0;
                if (|pending_q) begin
                    target_d    = pick;
                    dir_up_d    = pick_up;
                    floor_btn_d = ONE << pick;
                    state_d     = StPresent;
                end
            end
            StPresent: begin
                if ((cur == target_q) && bus.door) begin
                    floor_btn_d = '0;
                    dwell_d     = '0;
                    state_d     = StDwell;
                end
            end
            StDwell: begin
                floor_btn_d = '0;
                if (dwell_q == DW'(DWELL_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                floor_btn_d = '0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            pending_q   <= '0;
            floor_btn_q <= '0;
            target_q    <= '0;
            dir_up_q    <= 1'b1;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bus.btn_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            pending_q   <= pending_d;
            floor_btn_q <= floor_btn_d;
            target_q    <= target_d;
            dir_up_q    <= dir_up_d;
            dwell_q     <= dwell_d;
        end
    end

    assign bus.floor_btn = floor_btn_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
